// File: rtl/cam_dvp_tx_if.sv
// Bus between cam_dvp_tx and its consumer: frame control, the DVP byte stream and,
// with CAM_DVP_TX_EXT_PIX_EN defined, the external pixel read port.
interface cam_dvp_tx_if
`ifdef CAM_DVP_TX_EXT_PIX_EN
  #(parameter int ADDR_W = 17)
`endif
  ;
  logic       i_start;
  logic       i_cont;
  logic       o_cam_vsync;
  logic       o_cam_hsync;
  logic [7:0] o_cam_data;
  logic       o_frame_done;
  logic       o_busy;
`ifdef CAM_DVP_TX_EXT_PIX_EN
  logic              o_px_rd_en;
  logic [ADDR_W-1:0] o_px_addr;
  logic [15:0]       i_px_data;

  modport master (input  i_start, i_cont, i_px_data,
                  output o_cam_vsync, o_cam_hsync, o_cam_data, o_frame_done, o_busy,
                         o_px_rd_en, o_px_addr);
  modport slave  (output i_start, i_cont, i_px_data,
                  input  o_cam_vsync, o_cam_hsync, o_cam_data, o_frame_done, o_busy,
                         o_px_rd_en, o_px_addr);
`else
  modport master (input  i_start, i_cont,
                  output o_cam_vsync, o_cam_hsync, o_cam_data, o_frame_done, o_busy);
  modport slave  (output i_start, i_cont,
                  input  o_cam_vsync, o_cam_hsync, o_cam_data, o_frame_done, o_busy);
`endif
endinterface

// File: rtl/cam_dvp_tx.sv
// DVP camera-style frame generator emitting RGB565 bytes (high byte first).
// CAM_DVP_TX_EXT_PIX_EN: pixels read from an external port instead of the colour-bar pattern.
module cam_dvp_tx #(
  parameter int H_ACT   = 480,
  parameter int V_ACT   = 272,
  parameter int H_BLANK = 64,
  parameter int V_SYNC  = 16,
  parameter int V_BP    = 32,
  parameter int V_FP    = 32,
  parameter int ADDR_W  = 17
) (
  input logic          i_clk,
  input logic          i_rst,
  cam_dvp_tx_if.master bus
);

  localparam int BAR_W   = H_ACT / 8;
  localparam int X_W     = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int LINE_W  = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int BARC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int MAX_A   = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int MAX_B   = (H_BLANK > V_FP) ? H_BLANK : V_FP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if ((H_ACT < 8) || (H_ACT % 8 != 0)) begin : g_bad_h_act
    $error("cam_dvp_tx: H_ACT must be a nonzero multiple of 8");
  end
  if (longint'(H_ACT) * longint'(V_ACT) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("cam_dvp_tx: ADDR_W too narrow for one frame of pixels");
  end

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [X_W-1:0]      x;
  logic [LINE_W-1:0]   line;
  logic [2:0]          bar;
  logic [BARC_W-1:0]   bar_cnt;
  logic                phase;
`ifdef CAM_DVP_TX_EXT_PIX_EN
  logic [ADDR_W-1:0]   addr;
`endif

  // Frame sequencer; bar index advances from a width counter so no divider is needed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      x       <= '0;
      line    <= '0;
      bar     <= '0;
      bar_cnt <= '0;
      phase   <= 1'b0;
`ifdef CAM_DVP_TX_EXT_PIX_EN
      addr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.i_start) state <= VSYNC;
        end
        VSYNC: begin
`ifdef CAM_DVP_TX_EXT_PIX_EN
          addr <= '0;
`endif
          if (cnt == CNT_W'(V_SYNC - 1)) begin
            state <= VBP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        VBP: begin
          if (cnt == CNT_W'(V_BP - 1)) begin
            state   <= ACTIVE;
            cnt     <= '0;
            line    <= '0;
            x       <= '0;
            bar     <= '0;
            bar_cnt <= '0;
            phase   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACTIVE: begin
          phase <= ~phase;
          if (phase) begin
`ifdef CAM_DVP_TX_EXT_PIX_EN
            addr <= addr + 1'b1;
`endif
            if (x == X_W'(H_ACT - 1)) begin
              state <= HBLANK;
              cnt   <= '0;
            end else begin
              x <= x + 1'b1;
              if (bar_cnt == BARC_W'(BAR_W - 1)) begin
                bar_cnt <= '0;
                bar     <= bar + 1'b1;
              end else begin
                bar_cnt <= bar_cnt + 1'b1;
              end
            end
          end
        end
        HBLANK: begin
          if (cnt == CNT_W'(H_BLANK - 1)) begin
            cnt <= '0;
            if (line == LINE_W'(V_ACT - 1)) begin
              state <= VFP;
            end else begin
              state   <= ACTIVE;
              line    <= line + 1'b1;
              x       <= '0;
              bar     <= '0;
              bar_cnt <= '0;
              phase   <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        VFP: begin
          if (cnt == CNT_W'(V_FP - 1)) begin
            cnt   <= '0;
            state <= bus.i_cont ? VSYNC : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic s0_hs, s0_vs, s0_done, s0_busy;
  assign s0_hs   = (state == ACTIVE);
  assign s0_vs   = (state == VSYNC);
  assign s0_done = (state == VFP) && (cnt == CNT_W'(V_FP - 1));
  assign s0_busy = (state != IDLE);

  logic vs_p1, hs_p1, ph_p1, done_p1, busy_p1;
  logic vs_p2, hs_p2, ph_p2, done_p2, busy_p2;
`ifdef CAM_DVP_TX_EXT_PIX_EN
  logic [7:0] px_low;
`else
  logic [15:0] col_s0, col_p1, col_p2;

  always_comb begin
    col_s0 = 16'h0000;
    case (bar)
      3'd0: col_s0 = 16'hFFFF;
      3'd1: col_s0 = 16'hFFE0;
      3'd2: col_s0 = 16'h07FF;
      3'd3: col_s0 = 16'h07E0;
      3'd4: col_s0 = 16'hF81F;
      3'd5: col_s0 = 16'hF800;
      3'd6: col_s0 = 16'h001F;
      default: col_s0 = 16'h0000;
    endcase
  end
`endif

  // Two-stage delay lets a read issued at stage 1 return in time, so bytes and syncs leave together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      {vs_p1, hs_p1, ph_p1, done_p1, busy_p1} <= '0;
      {vs_p2, hs_p2, ph_p2, done_p2, busy_p2} <= '0;
      bus.o_cam_vsync  <= 1'b0;
      bus.o_cam_hsync  <= 1'b0;
      bus.o_cam_data   <= 8'h00;
      bus.o_frame_done <= 1'b0;
      bus.o_busy       <= 1'b0;
`ifdef CAM_DVP_TX_EXT_PIX_EN
      px_low         <= 8'h00;
      bus.o_px_rd_en <= 1'b0;
      bus.o_px_addr  <= '0;
`else
      col_p1 <= 16'h0000;
      col_p2 <= 16'h0000;
`endif
    end else begin
      {vs_p1, hs_p1, ph_p1, done_p1, busy_p1} <= {s0_vs, s0_hs, phase & s0_hs, s0_done, s0_busy};
      {vs_p2, hs_p2, ph_p2, done_p2, busy_p2} <= {vs_p1, hs_p1, ph_p1, done_p1, busy_p1};
      bus.o_cam_vsync  <= vs_p2;
      bus.o_cam_hsync  <= hs_p2;
      bus.o_frame_done <= done_p2;
      bus.o_busy       <= busy_p2;
`ifdef CAM_DVP_TX_EXT_PIX_EN
      bus.o_px_rd_en <= s0_hs & ~phase;
      bus.o_px_addr  <= addr;
      if (hs_p2 && !ph_p2) begin
        bus.o_cam_data <= bus.i_px_data[15:8];
        px_low         <= bus.i_px_data[7:0];
      end else if (hs_p2) begin
        bus.o_cam_data <= px_low;
      end else begin
        bus.o_cam_data <= 8'h00;
      end
`else
      col_p1 <= col_s0;
      col_p2 <= col_p1;
      if (!hs_p2)     bus.o_cam_data <= 8'h00;
      else if (ph_p2) bus.o_cam_data <= col_p2[7:0];
      else            bus.o_cam_data <= col_p2[15:8];
`endif
    end
  end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Self-checking bench for cam_dvp_tx: randomized control against a frame-position model.
// Honours CAM_DVP_TX_EXT_PIX_EN by serving pixel value = read address.
module tb_cam_dvp_tx;

  localparam int H_ACT   = 8;
  localparam int V_ACT   = 2;
  localparam int H_BLANK = 4;
  localparam int V_SYNC  = 3;
  localparam int V_BP    = 2;
  localparam int V_FP    = 2;
  localparam int ADDR_W  = 17;
  localparam int LINE_T  = 2 * H_ACT + H_BLANK;
  localparam int PERIOD  = V_SYNC + V_BP + V_ACT * LINE_T + V_FP;
  localparam logic [15:0] COLOURS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;
  int   expAddr    = 0;
  bit   seen;

`ifdef CAM_DVP_TX_EXT_PIX_EN
  cam_dvp_tx_if #(.ADDR_W(ADDR_W)) bus();
`else
  cam_dvp_tx_if bus();
`endif

  cam_dvp_tx #(.H_ACT(H_ACT), .V_ACT(V_ACT), .H_BLANK(H_BLANK), .V_SYNC(V_SYNC),
               .V_BP(V_BP), .V_FP(V_FP), .ADDR_W(ADDR_W))
    dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] pixelValue(input int line, input int x);
    int idx;
    idx = line * H_ACT + x;
`ifdef CAM_DVP_TX_EXT_PIX_EN
    return 16'(idx);
`else
    return COLOURS[(idx % H_ACT) / (H_ACT / 8)];
`endif
  endfunction

  // Expected {vsync, hsync, data, frame_done, busy} at offset k from the vsync rise.
  function automatic logic [11:0] modelOut(input int k);
    logic       vs, hs, done;
    logic [7:0] d;
    logic [15:0] px;
    int r, line;
    vs = 1'b0; hs = 1'b0; done = 1'b0; d = 8'h00;
    r = k;
    if (r < V_SYNC) begin
      vs = 1'b1;
    end else begin
      r -= V_SYNC;
      if (r >= V_BP) begin
        r -= V_BP;
        line = r / LINE_T;
        if (line < V_ACT) begin
          r = r % LINE_T;
          if (r < 2 * H_ACT) begin
            hs = 1'b1;
            px = pixelValue(line, r / 2);
            d  = (r % 2 == 0) ? px[15:8] : px[7:0];
          end
        end else begin
          r -= V_ACT * LINE_T;
          done = (r == V_FP - 1);
        end
      end
    end
    return {vs, hs, d, done, 1'b1};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.o_cam_vsync, bus.o_cam_hsync, bus.o_cam_data, bus.o_frame_done, bus.o_busy};
  endfunction

  task automatic applyStimulus(input logic start, input logic cont);
    bus.i_start = start;
    bus.i_cont  = cont;
  endtask

  task automatic stepCycle();
    @(posedge i_clk);
    #1;
`ifdef CAM_DVP_TX_EXT_PIX_EN
    if (bus.o_px_rd_en) begin
      checkOutput("px_addr", 32'(bus.o_px_addr), 32'(expAddr));
      bus.i_px_data = 16'(bus.o_px_addr);
      expAddr++;
    end
`endif
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      checkOutput(tag, 32'(observed()), 32'd0);
    end
  endtask

  task automatic waitVsync(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      stepCycle();
      if (bus.o_cam_vsync) ok = 1'b1;
      else checkOutput("pre_vsync", 32'(observed()), 32'd0);
    end
    if (!ok) checkOutput("vsync_timeout", 32'd0, 32'd1);
  endtask

  task automatic runFrame(input int n, input bit firstTaken, input bit startNoise, input bit dropCont);
    expAddr = 0;
    for (int k = 0; k < n; k++) begin
      if (!(k == 0 && firstTaken)) stepCycle();
      checkOutput($sformatf("frame_k%0d", k), 32'(observed()), 32'(modelOut(k)));
      if (startNoise) bus.i_start = (k < PERIOD - 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (dropCont && k == PERIOD / 2) bus.i_cont = 1'b0;
    end
  endtask

  task automatic fullFrame();
    bit ok;
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("start_latency", 32'(observed()), 32'd0);
    applyStimulus(1'b0, 1'b0);
    waitVsync(ok);
    if (ok) begin
      runFrame(PERIOD, 1'b1, 1'b0, 1'b0);
`ifdef CAM_DVP_TX_EXT_PIX_EN
      checkOutput("px_count", 32'(expAddr), 32'(H_ACT * V_ACT));
`endif
    end
    stepCycle();
    checkOutput("idle_after_frame", 32'(observed()), 32'd0);
    idleCycles(3, "idle_after_frame");
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
`ifdef CAM_DVP_TX_EXT_PIX_EN
    bus.i_px_data = 16'h0000;
`endif
    i_rst = 1'b1;
    repeat (3) stepCycle();
    checkOutput("reset_out", 32'(observed()), 32'd0);
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b1);
    idleCycles($urandom_range(3, 8), "idle_no_start");

    $display("[TB] single frame");
    fullFrame();

    $display("[TB] continuous frames with start noise");
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b1);
    waitVsync(seen);
    if (seen) begin
      runFrame(PERIOD, 1'b1, 1'b1, 1'b0);
      runFrame(PERIOD, 1'b0, 1'b1, 1'b1);
    end
    stepCycle();
    checkOutput("idle_after_cont", 32'(observed()), 32'd0);
    idleCycles(3, "idle_after_cont");

    $display("[TB] reset during vsync");
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    waitVsync(seen);
    if (seen) runFrame(2, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b1;
    #1;
    checkOutput("rst_in_vsync", 32'(observed()), 32'd0);
    stepCycle();
    i_rst = 1'b0;
    idleCycles(5, "idle_after_rst_vsync");

    $display("[TB] reset mid-line");
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    waitVsync(seen);
    if (seen) runFrame(V_SYNC + V_BP + LINE_T + 5, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b1;
    #1;
    checkOutput("rst_mid_line", 32'(observed()), 32'd0);
    repeat (2) stepCycle();
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    idleCycles($urandom_range(5, 15), "idle_after_rst_line");
    applyStimulus(1'b0, 1'b0);
    fullFrame();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
